// File: rtl/watermark_detect_if.sv
// Pixel/control bundle between a watermarked pixel source and the
// watermark detector.
//
// Signals:
//   start       begin a detection run (sampled by the detector only when idle)
//   key         LFSR seed, latched on an accepted start
//   WM_select   1 = two watermark bits per pixel, 0 = one bit per pixel
//   pix_valid   pix_data carries a pixel this cycle
//   pix_data    watermarked pixel, bit0 = wm0, bit1 = wm1
//   busy        run in progress
//   done        one-cycle result strobe
//   detected    watermark-present flag, held between runs
//   match_count number of agreeing watermark bits, held between runs
//
// master: pixel source / controller side; slave: detector side.
interface watermark_detect_if #(
    parameter int NUM_PIX = 256
);
    localparam int CNT_W = $clog2(2 * NUM_PIX + 1);

    logic             start;
    logic [7:0]       key;
    logic             WM_select;
    logic             pix_valid;
    logic [7:0]       pix_data;
    logic             busy;
    logic             done;
    logic             detected;
    logic [CNT_W-1:0] match_count;

    modport master (
        output start, key, WM_select, pix_valid, pix_data,
        input  busy, done, detected, match_count
    );

    modport slave (
        input  start, key, WM_select, pix_valid, pix_data,
        output busy, done, detected, match_count
    );
endinterface

// File: rtl/watermark_detect.sv
// Keyed watermark detector.
//
// Regenerates the key-seeded LFSR watermark stream and compares it with the
// watermark bits carried in the LSBs of NUM_PIX incoming pixels. At the end of
// the run the number of agreeing bits is compared against THRESH_NUM eighths
// of the compared bits to decide whether the watermark is present.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset; aborts a run without a done pulse
//   bus  watermark_detect_if.slave (start/key/WM_select/pix_* in,
//        busy/done/detected/match_count out)
module watermark_detect #(
    parameter int NUM_PIX    = 256,
    parameter int THRESH_NUM = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    watermark_detect_if.slave    bus
);
    localparam int CNT_W = $clog2(2 * NUM_PIX + 1);
    localparam int PIX_W = $clog2(NUM_PIX + 1);
    // Wide enough for 8 * match_count and for 2*NUM_PIX*8.
    localparam int CMP_W = CNT_W + 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        EVAL
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [7:0]       lfsr;
    logic             sel;
    logic [CNT_W-1:0] match_count;
    logic [PIX_W-1:0] pix_cnt;
    logic             busy;
    logic             done;
    logic             detected;

    logic             load;
    logic             accept;
    logic             eval;
    logic             last_pix;
    logic             e0;
    logic             e1;
    logic [CNT_W-1:0] hits;
    logic             unused_pix_hi;

    // Fibonacci LFSR, taps 8,6,5,4.
    function automatic logic [7:0] lfsr_step(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

    // match_count*8 >= total*THRESH_NUM, evaluated without overflow.
    function automatic logic thresh_met(input logic [CNT_W-1:0] cnt, input logic s);
        logic [CMP_W-1:0] total;
        logic [CMP_W-1:0] lhs;
        logic [CMP_W-1:0] rhs;
        total = s ? CMP_W'(2 * NUM_PIX) : CMP_W'(NUM_PIX);
        lhs   = CMP_W'({cnt, 3'b000});
        rhs   = total * CMP_W'(THRESH_NUM);
        return lhs >= rhs;
    endfunction

    assign e0       = lfsr[0];
    assign e1       = lfsr[1] ^ lfsr[0];
    assign last_pix = (pix_cnt == PIX_W'(NUM_PIX - 1));

    // Bit agreements contributed by the current pixel; wm1 counts only in
    // two-bit mode.
    assign hits = CNT_W'(bus.pix_data[0] == e0)
                + CNT_W'(sel && (bus.pix_data[1] == e1));

    // Upper pixel bits carry image content, not watermark.
    assign unused_pix_hi = ^bus.pix_data[7:2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        accept    = 1'b0;
        eval      = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (bus.pix_valid) begin
                    accept = 1'b1;
                    if (last_pix) begin
                        state_nxt = EVAL;
                    end
                end
            end
            EVAL: begin
                eval      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr        <= 8'h01;
            sel         <= 1'b0;
            match_count <= '0;
            pix_cnt     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            detected    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                // All-zero is the LFSR lock-up state, so a zero key seeds 01.
                lfsr        <= (bus.key == 8'h00) ? 8'h01 : bus.key;
                sel         <= bus.WM_select;
                match_count <= '0;
                pix_cnt     <= '0;
                detected    <= 1'b0;
                busy        <= 1'b1;
            end
            if (accept) begin
                match_count <= match_count + hits;
                lfsr        <= lfsr_step(lfsr);
                pix_cnt     <= pix_cnt + PIX_W'(1);
            end
            if (eval) begin
                detected <= thresh_met(match_count, sel);
                done     <= 1'b1;
                busy     <= 1'b0;
            end
        end
    end

    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.detected    = detected;
    assign bus.match_count = match_count;
endmodule

// File: tb/tb_watermark_detect.sv
// Bench for watermark_detect: three detectors (5 pixels at thresholds 7 and 8
// sharing one stimulus, and 256 pixels at threshold 7). Expected results are
// queued when a run is issued and checked when each detector strobes done.
module tb_watermark_detect;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    watermark_detect_if #(.NUM_PIX(5))   b5();
    watermark_detect_if #(.NUM_PIX(5))   b5t8();
    watermark_detect_if #(.NUM_PIX(256)) b256();

    watermark_detect #(.NUM_PIX(5), .THRESH_NUM(7)) dut5 (
        .clk(clk), .rst(rst), .bus(b5.slave)
    );
    watermark_detect #(.NUM_PIX(5), .THRESH_NUM(8)) dut5t8 (
        .clk(clk), .rst(rst), .bus(b5t8.slave)
    );
    watermark_detect #(.NUM_PIX(256), .THRESH_NUM(7)) dut256 (
        .clk(clk), .rst(rst), .bus(b256.slave)
    );

    assign b5t8.start     = b5.start;
    assign b5t8.key       = b5.key;
    assign b5t8.WM_select = b5.WM_select;
    assign b5t8.pix_valid = b5.pix_valid;
    assign b5t8.pix_data  = b5.pix_data;

    int n_checks = 0;
    int n_pass   = 0;
    int q5[$];
    int q5t8[$];
    int q256[$];
    logic pd5   = 1'b0;
    logic pd5t8 = 1'b0;
    logic pd256 = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    // Scoreboard monitors: expected entry = match_count*2 + detected.
    always @(negedge clk) begin
        if (b5.done) begin
            check("done5_single_pulse", pd5, 0);
            check("busy5_low_with_done", b5.busy, 0);
            if (q5.size() == 0) check("done5_unexpected", 1, 0);
            else begin
                int e;
                e = q5.pop_front();
                check("mc5", b5.match_count, e >> 1);
                check("det5", b5.detected, e & 1);
            end
        end
        pd5 <= b5.done;
    end

    always @(negedge clk) begin
        if (b5t8.done) begin
            check("done5t8_single_pulse", pd5t8, 0);
            if (q5t8.size() == 0) check("done5t8_unexpected", 1, 0);
            else begin
                int e;
                e = q5t8.pop_front();
                check("mc5t8", b5t8.match_count, e >> 1);
                check("det5t8", b5t8.detected, e & 1);
            end
        end
        pd5t8 <= b5t8.done;
    end

    always @(negedge clk) begin
        if (b256.done) begin
            check("done256_single_pulse", pd256, 0);
            check("busy256_low_with_done", b256.busy, 0);
            if (q256.size() == 0) check("done256_unexpected", 1, 0);
            else begin
                int e;
                e = q256.pop_front();
                check("mc256", b256.match_count, e >> 1);
                check("det256", b256.detected, e & 1);
            end
        end
        pd256 <= b256.done;
    end

    // Five-pixel run; px holds the first pixel in its leftmost byte.
    task automatic run5(input logic [7:0] k, input logic s, input logic [39:0] px,
                        input bit gaps, input int emc, input bit edet, input bit edet8);
        q5.push_back(emc * 2 + int'(edet));
        q5t8.push_back(emc * 2 + int'(edet8));
        b5.start     = 1'b1;
        b5.key       = k;
        b5.WM_select = s;
        @(negedge clk);
        b5.start     = 1'b0;
        b5.key       = 8'hFF;
        b5.WM_select = ~s;
        check("busy5_after_start", b5.busy, 1);
        for (int i = 0; i < 5; i++) begin
            if (gaps) begin
                int ng;
                ng = (i == 2) ? 1 : int'($urandom_range(0, 2));
                for (int g = 0; g < ng; g++) begin
                    b5.pix_valid = 1'b0;
                    b5.pix_data  = ~px[39-8*i -: 8];
                    b5.start     = (i == 2);
                    b5.key       = 8'h77;
                    @(negedge clk);
                    b5.start     = 1'b0;
                end
            end
            b5.pix_valid = 1'b1;
            b5.pix_data  = px[39-8*i -: 8];
            if (i < 4) @(negedge clk);
        end
        @(posedge clk);
        #1;
        check("done5_not_early", b5.done, 0);
        check("busy5_in_eval", b5.busy, 1);
        b5.pix_valid = 1'b0;
        @(posedge clk);
        #1;
        check("done5_latency", b5.done, 1);
        check("busy5_falls_with_done", b5.busy, 0);
        @(negedge clk);
    endtask

    // 256-pixel two-bit run; every odd pixel up to 2*ncor-1 has wm0 flipped.
    task automatic run256(input logic [7:0] k, input int ncor, input int emc, input bit edet);
        logic [7:0] q;
        logic [7:0] p;
        q = (k == 8'h00) ? 8'h01 : k;
        q256.push_back(emc * 2 + int'(edet));
        b256.start     = 1'b1;
        b256.key       = k;
        b256.WM_select = 1'b1;
        @(negedge clk);
        b256.start = 1'b0;
        for (int i = 0; i < 256; i++) begin
            p = {6'b101101, q[1] ^ q[0], q[0]};
            if ((i % 2 == 1) && (i / 2 < ncor)) p[0] = ~p[0];
            b256.pix_valid = 1'b1;
            b256.pix_data  = p;
            @(negedge clk);
            q = {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
        end
        b256.pix_valid = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst            = 1'b1;
        b5.start       = 1'b0;
        b5.key         = 8'h00;
        b5.WM_select   = 1'b0;
        b5.pix_valid   = 1'b0;
        b5.pix_data    = 8'h00;
        b256.start     = 1'b0;
        b256.key       = 8'h00;
        b256.WM_select = 1'b0;
        b256.pix_valid = 1'b0;
        b256.pix_data  = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_busy", b5.busy, 0);
        check("rst_done", b5.done, 0);
        check("rst_detected", b5.detected, 0);
        check("rst_match_count", b5.match_count, 0);
        check("rst_match_count256", b256.match_count, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Reference stream: expected {e1,e0} = 3,2,0,0,3.
        run5(8'h01, 1'b1, 40'hA3_A2_A0_A0_A3, 1'b0, 10, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        check("mc5_held", b5.match_count, 10);
        check("det5_held", b5.detected, 1);

        // Both watermark bits inverted on every pixel.
        run5(8'h01, 1'b1, 40'hA0_A1_A3_A3_A0, 1'b0, 0, 1'b0, 1'b0);
        // One wm0 miss: 72 >= 70 passes at 7/8, 72 < 80 fails at 8/8.
        run5(8'h01, 1'b1, 40'hA3_A2_A0_A0_A2, 1'b0, 9, 1'b1, 1'b0);
        // Zero key behaves as seed 01, one bit per pixel.
        run5(8'h00, 1'b0, 40'h01_00_00_00_01, 1'b0, 5, 1'b1, 1'b1);
        // Gaps on pix_valid and a start pulse mid-run.
        run5(8'h01, 1'b1, 40'hA3_A2_A0_A0_A3, 1'b1, 10, 1'b1, 1'b1);

        // Abort after three pixels.
        b5.start     = 1'b1;
        b5.key       = 8'h01;
        b5.WM_select = 1'b1;
        @(negedge clk);
        b5.start     = 1'b0;
        b5.pix_valid = 1'b1;
        b5.pix_data  = 8'hA3;
        @(negedge clk);
        b5.pix_data  = 8'hA2;
        @(negedge clk);
        b5.pix_data  = 8'hA0;
        @(negedge clk);
        b5.pix_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("abort_busy", b5.busy, 0);
        check("abort_done", b5.done, 0);
        check("abort_match_count", b5.match_count, 0);
        check("abort_detected", b5.detected, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        run5(8'h01, 1'b1, 40'hA3_A2_A0_A0_A3, 1'b0, 10, 1'b1, 1'b1);

        // 512 compared bits; threshold 3584 in eighths.
        run256(8'h5A, 40, 472, 1'b1);
        run256(8'h5A, 80, 432, 1'b0);

        for (int t = 0; t < 50 && (q5.size() + q5t8.size() + q256.size()) != 0; t++)
            @(negedge clk);
        check("scoreboard_drained", q5.size() + q5t8.size() + q256.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/watermark_detect.md
Name: watermark_detect

Overview:
Extraction-side counterpart of the keyed watermark generator. It regenerates the same key-seeded LFSR watermark stream and compares it against the watermark bits carried in the LSBs of incoming pixels. Over a frame of NUM_PIX pixels it counts bit agreements and reports whether the watermark is present. It sits after the pixel source in the verification/extraction path.

Parameters:
NUM_PIX, 256, pixels compared per detection run (>=1)
THRESH_NUM, 7, detection threshold in eighths of compared bits (0..8)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  begin a detection run; sampled only in IDLE
key  input  8  LFSR seed, latched on accepted start
WM_select  input  1  1 = 2 watermark bits/pixel, 0 = 1 bit/pixel; latched on accepted start
pix_valid  input  1  pix_data valid this cycle
pix_data  input  8  watermarked pixel; bit0 = wm0, bit1 = wm1
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse when the result is valid
detected  output  1  result flag, held until the next accepted start
match_count  output  clog2(2*NUM_PIX+1)  bit agreements, held until the next accepted start

Behaviour:
- Reset (async, immediate): state IDLE; LFSR=8'h01; busy=0, done=0, detected=0, match_count=0, pixel count=0. Reset mid-run aborts the run with no done pulse.
- LFSR q[7:0], Fibonacci, taps 8,6,5,4: fb = q7^q5^q4^q3; next = {q[6:0],fb}. Seed = key; key==0 seeds 8'h01 because the all-zero state is illegal.
- Expected bits from current q: e0 = q0; e1 = q1^q0 if sel, else unused.
- States: IDLE, RUN, EVAL.
- IDLE: on start=1, load LFSR seed, latch sel=WM_select, clear match_count and pixel count, set busy=1, go to RUN. start=0 leaves all outputs held.
- RUN: on each edge with pix_valid=1, add (pix_data[0]==e0) plus (sel & pix_data[1]==e1) to match_count, advance LFSR one step, increment pixel count. pix_valid=0 means no change, so gaps are allowed. After the NUM_PIX-th accepted pixel, go to EVAL. pix_data[7:2] is ignored.
- EVAL (one cycle): total = NUM_PIX*(1+sel). Set detected = (match_count*8 >= total*THRESH_NUM), using widths large enough that nothing overflows. Pulse done=1 for exactly this cycle, set busy=0, go to IDLE.
- Latency: if the last pixel is accepted at edge N, done, detected and match_count are all valid in the cycle after edge N+1.
- start while busy is ignored. pix_valid in IDLE or EVAL is ignored.
- match_count saturation is not needed: its maximum is 2*NUM_PIX.
- THRESH_NUM=0 always gives detected=1. THRESH_NUM=8 requires every bit to match.

Test Plan:
- Reference sequence, key=8'h01, sel=1, NUM_PIX=5. The LFSR runs 01,02,04,08,11 and the expected {e1,e0} values are 3,2,0,0,3. Feed pixels A3,A2,A0,A0,A3 -> match_count=10, detected=1, done is a single pulse one cycle after the EVAL entry edge, and busy falls with done.
- Same setup with bits[1:0] inverted on every pixel (A0,A1,A3,A3,A0) -> match_count=0, detected=0.
- key=8'h00, sel=0, NUM_PIX=5, pixels 01,00,00,00,01 -> behaves exactly as seed 01: match_count=5, detected=1.
- Default NUM_PIX=256, sel=1, key=8'h5A, stream from the model with the LSBs of 40 pixels corrupted (bit0 only) -> match_count=472. Since 472*8=3776 >= 512*7=3584, detected=1. With 80 pixels corrupted: match_count=432, 3456 < 3584, so detected=0.
- pix_valid toggled 1-0-1 at random, plus start pulsed mid-run -> results identical to the gapless run, and the second start has no effect.
- rst asserted after 3 of 5 pixels, then a fresh start and full matching stream -> no done during the aborted run, and the new run gives match_count=10, detected=1.
